// File: rtl/step_motor_sequencer.sv
// Bipolar stepper phase sequencer for one motor axis.
// Takes a step/direction command, paces steps with a period divider,
// walks the 8-entry phase table in full- or half-step mode, aborts on
// stop or on the end-stop ahead of the motion, and tracks position.
module step_motor_sequencer #(
    parameter int PERIOD_W = 16,
    parameter int STEPS_W  = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [STEPS_W-1:0]  cmd_steps,
    input  logic                cmd_dir,
    input  logic                cmd_half,
    input  logic [PERIOD_W-1:0] period,
    input  logic                stop,
    input  logic                hold_en,
    input  logic                limit_pos,
    input  logic                limit_neg,
    output logic                ax,
    output logic                ay,
    output logic                bx,
    output logic                by,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [STEPS_W-1:0]  position
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t              state, state_next;
    logic [PERIOD_W-1:0] div_cnt;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] period_eff;
    logic [STEPS_W-1:0]  steps_left;
    logic [STEPS_W-1:0]  position_q;
    logic                dir_q;
    logic                half_q;
    logic                aborted_q;
    logic [2:0]          index;
    logic [2:0]          index_next;
    logic [2:0]          step_amt;
    logic [3:0]          coils;
    logic                tick;
    logic                limit_hit;
    logic                take_step;

    // Coil pattern for each phase index, ordered {ax, ay, bx, by}.
    function automatic logic [3:0] phase_of(input logic [2:0] idx);
        case (idx)
            3'd0:    phase_of = 4'b1000;
            3'd1:    phase_of = 4'b1010;
            3'd2:    phase_of = 4'b0010;
            3'd3:    phase_of = 4'b0110;
            3'd4:    phase_of = 4'b0100;
            3'd5:    phase_of = 4'b0101;
            3'd6:    phase_of = 4'b0001;
            default: phase_of = 4'b1001;
        endcase
    endfunction

    // A zero period would never let the divider count; run it as one.
    assign period_eff = (period == '0) ? PERIOD_W'(1) : period;

    // Step decision: the divider expiring in RUN is a step unless stop
    // or the end-stop in the direction of travel blocks it. A full step
    // from an even (one-coil) index moves one place to reach a two-coil
    // index; parity is kept from then on, so this only fires once.
    always_comb begin
        tick       = (state == RUN) && (div_cnt == '0);
        limit_hit  = dir_q ? limit_pos : limit_neg;
        take_step  = tick && !stop && !limit_hit;
        step_amt   = (half_q || !index[0]) ? 3'd1 : 3'd2;
        index_next = index;
        if (take_step) begin
            index_next = dir_q ? (index + step_amt) : (index - step_amt);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_next = (cmd_steps == '0) ? FINISH : RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = FINISH;
                end else if (tick) begin
                    if (limit_hit || steps_left == STEPS_W'(1)) begin
                        state_next = FINISH;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state register.
    always_comb begin
        cmd_ready = (state == IDLE);
        busy      = (state != IDLE);
        done      = (state == FINISH);
    end

    // Command latch, divider, step counter, index, position and abort flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt    <= '0;
            period_q   <= '0;
            steps_left <= '0;
            position_q <= '0;
            dir_q      <= 1'b0;
            half_q     <= 1'b0;
            aborted_q  <= 1'b0;
            index      <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        steps_left <= cmd_steps;
                        dir_q      <= cmd_dir;
                        half_q     <= cmd_half;
                        period_q   <= period_eff;
                        div_cnt    <= period_eff;
                        aborted_q  <= 1'b0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        aborted_q <= 1'b1;
                    end else if (tick) begin
                        if (limit_hit) begin
                            aborted_q <= 1'b1;
                        end else begin
                            index      <= index_next;
                            position_q <= dir_q ? position_q + STEPS_W'(1)
                                                : position_q - STEPS_W'(1);
                            steps_left <= steps_left - STEPS_W'(1);
                            div_cnt    <= period_q;
                        end
                    end else begin
                        div_cnt <= div_cnt - PERIOD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered coil drive, computed from the upcoming index and state so
    // the pattern changes on the same edge as the step; coast when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            coils <= hold_en ? phase_of(3'd0) : 4'b0000;
        end else if (state_next != IDLE || hold_en) begin
            coils <= phase_of(index_next);
        end else begin
            coils <= 4'b0000;
        end
    end

    assign {ax, ay, bx, by} = coils;
    assign aborted          = aborted_q;
    assign position         = position_q;

endmodule

// File: doc/step_motor_sequencer.md
# step_motor_sequencer

Generates bipolar stepper phase patterns (AX, AY, BX, BY) for one motor axis from a queued step/direction command. It owns step-rate timing, full/half-step sequencing, limit-switch abort and position tracking. One instance sits between the qsys control registers and each microscope/syringe axis driver port, and replaces software-toggled phase bits.

## Interface
Parameters:
- `PERIOD_W`, default 16: width of the step-period divider.
- `STEPS_W`, default 24: width of the step count and of the position counter.

Ports:
- `clk` in, 1: system clock.
- `reset` in, 1: synchronous, active-high.
- `cmd_valid` in, 1: command offered.
- `cmd_ready` out, 1: block can accept a command.
- `cmd_steps` in, STEPS_W: number of steps, unsigned.
- `cmd_dir` in, 1: 1 = positive (index increments), 0 = negative.
- `cmd_half` in, 1: 1 = half-step, 0 = full-step.
- `period` in, PERIOD_W: clocks per step, minus 1; sampled at accept. 0 is treated as 1.
- `stop` in, 1: abort the current command.
- `hold_en` in, 1: keep coils energised while idle.
- `limit_pos` in, 1: positive end-stop, active-high, already synchronised.
- `limit_neg` in, 1: negative end-stop, active-high, already synchronised.
- `ax`, `ay`, `bx`, `by` out, 1 each: coil phase outputs, active-high.
- `busy` out, 1: a command is executing.
- `done` out, 1: one-cycle pulse when a command ends.
- `aborted` out, 1: status of the last command; valid from `done`, held until the next accept.
- `position` out, STEPS_W: signed step position, two's complement, wraps.

## Operation
- **Phase table** (3-bit index to {ax,ay,bx,by}): 0:1000, 1:1010, 2:0010, 3:0110, 4:0100, 5:0101, 6:0001, 7:1001.
- **Half-step:** index ±1 mod 8 per step.
- **Full-step:** index ±2 mod 8 per step. If the index is even at the first step of a full-step command, that step moves ±1 so the block lands on an odd (two-coil) index. Every later step moves ±2.
- **Position:** +1 per step when `cmd_dir`=1, −1 when `cmd_dir`=0, regardless of step mode. It wraps modulo 2^STEPS_W.
- **Coil drive:** outputs show table[index] when `busy`=1 or `hold_en`=1. Otherwise all four outputs are 0 (coast).
- **FSM states:**
  - IDLE: `cmd_ready`=1. Accept on `cmd_valid`. Latch steps, dir, half and period, load the divider, clear `aborted`. If `cmd_steps`=0 go to FINISH, else go to RUN.
  - RUN: the divider decrements each cycle. When it reaches 0:
    - Limit check first: if the limit switch in the current direction is high, set `aborted`=1 and go to FINISH with no step.
    - Otherwise update the index and position, decrement steps_left and reload the divider.
    - If steps_left becomes 0, go to FINISH.
  - FINISH: `done`=1 for one cycle, then IDLE.
- `stop`=1 in RUN goes to FINISH with `aborted`=1. If the divider is 0 in that same cycle, the step is not taken (`stop` wins).
- `stop` in IDLE or FINISH is ignored.
- `cmd_valid` while not ready is ignored. There is no queue, and the command must be held until accepted.
- The limit for the opposite direction is ignored, so an axis can always back off a switch.

## Timing
- **Reset values:** index=0, position=0, state IDLE, `cmd_ready`=1, `busy`=0, `done`=0, `aborted`=0, divider=0, steps_left=0. Outputs are 0000, or 1000 if `hold_en`=1.
- `reset` mid-command returns to IDLE on the next edge, with no `done` pulse.
- **Accept:** `cmd_valid`&`cmd_ready` at edge N. `busy`=1 and `cmd_ready`=0 from N+1.
- **First step:** the index and outputs change at edge N+P+1, where P = max(period,1). Subsequent steps follow every P+1 clocks.
- **Completion:** the last step is at edge L. `done`=1 and `busy`=1 during cycle L+1. `busy`=0 and `cmd_ready`=1 from L+2.
- **Zero steps:** `done` in cycle N+1, with no output change.
- **Outputs:** all outputs are registered. No combinational path from inputs to `ax`/`ay`/`bx`/`by`.

## Test plan
- **Reset:** assert `reset` with `hold_en`=0, then release → outputs 0000, `position`=0, `cmd_ready`=1, `done`=0.
- **Full-step positive:** steps=4, dir=1, half=0, period=3, start index 0 → outputs 1010, 0110, 0101, 1001 at accept+4, +8, +12, +16; `done` one cycle later; `position`=4.
- **Half-step negative with wrap:** from index 0, steps=3, dir=0, half=1, period=0 → outputs 1001, 0001, 0101 every 2 clocks; `position`=−3 (0xFFFFFD).
- **Limit abort:** dir=1, steps=100, `limit_pos` raised after 5 steps → no 6th step, `done` pulse, `aborted`=1, `position`=5. A following dir=0 command with `limit_pos` still high executes normally.
- **Stop versus step:** assert `stop` in the same cycle the divider hits 0 → no index change, `aborted`=1, `done` next cycle.
- **Command handling:** `cmd_steps`=0 → `done` at N+1, outputs unchanged. `cmd_valid` while `busy` → ignored. Reset mid-run → IDLE with no `done` pulse.
